// File: rtl/cla_nibble_serial_adder_if.sv
// Operand/result bus of the nibble-serial CLA adder. The ovf wire exists only
// when CLA_SERIAL_OVF_EN is defined.
interface cla_nibble_serial_adder_if #(
    parameter int WIDTH = 16
);
    // Valid/ready: a transfer happens on a rising edge where valid && ready;
    // the producer holds valid and its payload stable until that edge.
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
`ifdef CLA_SERIAL_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, busy
`ifdef CLA_SERIAL_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, busy
`ifdef CLA_SERIAL_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/cla_nibble_serial_adder.sv
// WIDTH-bit adder that runs one 4-bit carry-lookahead slice over N = WIDTH/4 cycles.
// Optional signed-overflow flag enabled by defining CLA_SERIAL_OVF_EN.
module cla_nibble_serial_adder #(
    parameter int WIDTH = 16  // multiple of 4, at least 4
) (
    input  logic                        clk,
    input  logic                        rst,
    cla_nibble_serial_adder_if.slave    bus,
    output logic [1:0]                  dbg_state
);
    localparam int N     = WIDTH / 4;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;
    logic               carry_q;
    logic               init_q;
    logic [IDX_W-1:0]   idx;
    logic [3:0]         nib_a;
    logic [3:0]         nib_b;
    logic [3:0]         nib_s;
    logic [3:0]         g;
    logic [3:0]         p;
    logic [4:0]         c;
    logic               last;
    logic               accept;
`ifdef CLA_SERIAL_OVF_EN
    logic               ovf_q;
`endif

    // The single 4-bit carry-lookahead slice, fed from the latched operands.
    always_comb begin
        nib_a = op_a[4*idx +: 4];
        nib_b = op_b[4*idx +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        c[0]  = carry_q;
        c[1]  = g[0] | (p[0] & c[0]);
        c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
        c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
        nib_s = p ^ c[3:0];
    end

    assign last = (idx == IDX_W'(N - 1));

    always_comb begin
        state_next    = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        accept        = 1'b0;
        case (state)
            IDLE: begin
                // init_q keeps ready low until the first edge after reset release.
                bus.in_ready = init_q;
                if (bus.in_valid && init_q) begin
                    accept     = 1'b1;
                    state_next = ADD;
                end
            end
            ADD: begin
                bus.busy = 1'b1;
                if (last) state_next = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q  <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            idx     <= '0;
`ifdef CLA_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            init_q <= 1'b1;
            if (accept) begin
                op_a    <= bus.a;
                op_b    <= bus.b;
                carry_q <= bus.cin;
                idx     <= '0;
                sum_q   <= '0;
                cout_q  <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
                ovf_q   <= 1'b0;
`endif
            end else if (state == ADD) begin
                sum_q[4*idx +: 4] <= nib_s;
                carry_q           <= c[4];
                idx               <= idx + 1'b1;
                if (last) begin
                    cout_q <= c[4];
`ifdef CLA_SERIAL_OVF_EN
                    ovf_q  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) && (nib_s[3] != op_a[WIDTH-1]);
`endif
                end
            end
        end
    end

    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign dbg_state = state;
`ifdef CLA_SERIAL_OVF_EN
    assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Directed bench for cla_nibble_serial_adder (default WIDTH=16); ovf checks
// are compiled in when CLA_SERIAL_OVF_EN is defined.
module tb_cla_nibble_serial_adder;
    localparam int WIDTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         t0;
    logic [WIDTH:0] exp_q[$];

    cla_nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

    cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present an operand pair and return the cycle count at the accepting edge.
    task automatic send(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input bit hold, output int t_acc);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_ready_wait"}, 32'(bus.in_ready), 1);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = ci;
        bus.in_valid = 1'b1;
        tick();
        t_acc = cyc;
        if (!hold) bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int t_acc, input int exp_lat);
        int n = 0;
        logic [WIDTH:0] exp;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(cyc - t_acc), 32'(exp_lat));
        exp = exp_q.pop_front();
        check({tag, "_sum"}, 32'(bus.sum), 32'(exp[WIDTH-1:0]));
        check({tag, "_cout"}, 32'(bus.cout), 32'(exp[WIDTH]));
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
        bus.out_ready = 1'b0;

        #3;
        check("rst_sum", 32'(bus.sum), 0);
        check("rst_cout", 32'(bus.cout), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        check("rst_state", 32'(dbg_state), 0);
`ifdef CLA_SERIAL_OVF_EN
        check("rst_ovf", 32'(bus.ovf), 0);
`endif
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("ready_before_first_edge", 32'(bus.in_ready), 0);
        tick();
        check("ready_after_first_edge", 32'(bus.in_ready), 1);

        // 0x1234 + 0x4321, consumer always ready
        bus.out_ready = 1'b1;
        exp_q.push_back(17'h0_5555);
        send("t1", 16'h1234, 16'h4321, 1'b0, 1'b0, t0);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_in_ready_busy", 32'(bus.in_ready), 0);
        wait_done("t1", t0, 4);
        check("t1_state_done", 32'(dbg_state), 2);
        tick();
        check("t1_valid_one_cycle", 32'(bus.out_valid), 0);
        check("t1_back_to_idle", 32'(bus.in_ready), 1);

        // carry ripples through every nibble
        exp_q.push_back(17'h1_0000);
        send("t2", 16'hFFFF, 16'h0000, 1'b1, 1'b0, t0);
        wait_done("t2", t0, 4);
        tick();

`ifdef CLA_SERIAL_OVF_EN
        exp_q.push_back(17'h0_8000);
        send("ovf1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, t0);
        wait_done("ovf1", t0, 4);
        check("ovf1_flag", 32'(bus.ovf), 1);
        tick();
        exp_q.push_back(17'h1_0000);
        send("ovf2", 16'hFFFF, 16'h0001, 1'b0, 1'b0, t0);
        wait_done("ovf2", t0, 4);
        check("ovf2_flag", 32'(bus.ovf), 0);
        tick();
`endif

        // backpressure: result frozen, new operands refused
        bus.out_ready = 1'b0;
        exp_q.push_back(17'h0_0406);
        send("bp", 16'h0102, 16'h0304, 1'b0, 1'b0, t0);
        wait_done("bp", t0, 4);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.a        = 16'hAAAA ^ 16'(i);
            bus.b        = 16'h5555 ^ 16'(i);
            bus.cin      = 1'(i);
            tick();
            check("bp_hold_sum", 32'(bus.sum), 'h0406);
            check("bp_hold_cout", 32'(bus.cout), 0);
            check("bp_hold_valid", 32'(bus.out_valid), 1);
            check("bp_hold_ready", 32'(bus.in_ready), 0);
        end
        bus.a         = 16'hAAAA;
        bus.b         = 16'h5555;
        bus.cin       = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        exp_q.push_back(17'h1_0000);
        tick();
        check("bp_release_valid", 32'(bus.out_valid), 0);
        check("bp_release_ready", 32'(bus.in_ready), 1);
        tick();
        t0 = cyc;
        check("bp_next_accepted", 32'(bus.busy), 1);
        bus.in_valid = 1'b0;
        wait_done("bp_next", t0, 4);
        tick();

        // reset two ADD cycles into 0xABCD + 0x1111
        send("abort", 16'hABCD, 16'h1111, 1'b0, 1'b0, t0);
        tick();
        tick();
        check("abort_in_add", 32'(dbg_state), 1);
        rst = 1'b1;
        #1;
        check("abort_sum", 32'(bus.sum), 0);
        check("abort_cout", 32'(bus.cout), 0);
        check("abort_valid", 32'(bus.out_valid), 0);
        check("abort_busy", 32'(bus.busy), 0);
        check("abort_ready", 32'(bus.in_ready), 0);
        tick();
        rst = 1'b0;
        exp_q.push_back(17'h0_1000);
        send("post_abort", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, t0);
        wait_done("post_abort", t0, 4);
        tick();

        // back-to-back with in_valid and out_ready tied high
        exp_q.push_back(17'h0_0002);
        exp_q.push_back(17'h1_0000);
        send("b2b1", 16'h0001, 16'h0001, 1'b0, 1'b1, t0);
        bus.a = 16'h8000;
        bus.b = 16'h8000;
        wait_done("b2b1", t0, 4);
        tick();
        check("b2b_idle_ready", 32'(bus.in_ready), 1);
        tick();
        check("b2b_accept_gap", 32'(cyc - t0), 6);
        check("b2b_second_accepted", 32'(bus.busy), 1);
        t0 = cyc;
        bus.in_valid = 1'b0;
        wait_done("b2b2", t0, 4);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
